mult8_seq_ctrl: RTL and testbench



---
 rtl/mult8_seq_ctrl.sv | 160 ++++++++++++++++
 tb/tb_mult8_seq_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult8_seq_ctrl.sv
// 8x8->16 unsigned multiplier time-sharing one 4x4 core over four nibble steps; valid/ready both sides.
// PIPE registers the core product (+1 cycle). Optional MULT_MAC_ACC_EN adds a 20-bit running sum of products.

module mult4x4_core (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output logic [7:0] o_p
);
  // Shift-and-add array of AND rows; unsigned only.
  always_comb begin
    o_p = '0;
    for (int i = 0; i < 4; i++) begin
      o_p = o_p + ({4'b0000, i_a & {4{i_b[i]}}} << i);
    end
  end
endmodule

module mult8_seq_ctrl #(
  parameter int PIPE = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_p,
`ifdef MULT_MAC_ACC_EN
  input  logic        acc_clr,
  output logic [19:0] acc_out,
`endif
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  localparam logic [2:0] LAST_STEP = (PIPE != 0) ? 3'd4 : 3'd3;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_a;
  logic [7:0]  r_b;
  logic [2:0]  r_step;
  logic [15:0] r_acc;
  logic [3:0]  w_na;
  logic [3:0]  w_nb;
  logic [7:0]  w_core;
  logic [15:0] w_add;
  logic        w_accept;
  logic        w_last;

  function automatic logic [15:0] f_shift(input logic [7:0] pp, input logic [1:0] st);
    case (st)
      2'd0:    f_shift = {8'h00, pp};
      2'd3:    f_shift = {pp, 8'h00};
      default: f_shift = {4'h0, pp, 4'h0};
    endcase
  endfunction

  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_last   = (r_step == LAST_STEP);

  // step bit0 picks the A nibble, bit1 the B nibble
  assign w_na = r_step[0] ? r_a[7:4] : r_a[3:0];
  assign w_nb = r_step[1] ? r_b[7:4] : r_b[3:0];

  mult4x4_core u_core (
    .i_a (w_na),
    .i_b (w_nb),
    .o_p (w_core)
  );

  generate
    if (PIPE != 0) begin : g_pipe
      logic [7:0] r_pp;
      logic [1:0] w_prev;

      // The product in r_pp belongs to the previous step, so shift by that step.
      assign w_prev = r_step[1:0] - 2'd1;
      assign w_add  = (r_step == 3'd0) ? 16'h0000 : f_shift(r_pp, w_prev);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_pp <= '0;
        end else if (w_accept) begin
          r_pp <= '0;
        end else if (r_state == MUL) begin
          r_pp <= w_core;
        end
      end
    end else begin : g_nopipe
      assign w_add = f_shift(w_core, r_step[1:0]);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_nxt = MUL;
      MUL:     if (w_last)    w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
    busy      = (r_state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_step <= '0;
      r_acc  <= '0;
    end else if (w_accept) begin
      r_a    <= in_a;
      r_b    <= in_b;
      r_step <= '0;
      r_acc  <= '0;
    end else if (r_state == MUL) begin
      r_acc  <= r_acc + w_add;
      r_step <= r_step + 3'd1;
    end
  end

  assign out_p = r_acc;

`ifdef MULT_MAC_ACC_EN
  logic [19:0] r_mac;
  logic        w_hs;

  assign w_hs = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mac <= '0;
    end else if (acc_clr) begin
      r_mac <= w_hs ? {4'h0, out_p} : 20'h00000;
    end else if (w_hs) begin
      r_mac <= r_mac + {4'h0, out_p};
    end
  end

  assign acc_out = r_mac;
`endif

endmodule

// File: tb/tb_mult8_seq_ctrl.sv
// Directed bench for mult8_seq_ctrl: one PIPE=0 and one PIPE=1 instance sharing operand inputs.
module tb_mult8_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        v;
  logic        sel;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        out_ready;
  logic        in_valid0, in_valid1;
  logic        in_ready0, in_ready1;
  logic        out_valid0, out_valid1;
  logic [15:0] out_p0, out_p1;
  logic        busy0, busy1;
  logic        s_rdy, s_vld, s_busy;
  logic [15:0] s_p;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
`ifdef MULT_MAC_ACC_EN
  logic        acc_clr;
  logic        acc_clr1;
  logic [19:0] acc_out;
  logic [19:0] acc_out1;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign in_valid0 = v && !sel;
  assign in_valid1 = v && sel;
  assign s_rdy  = sel ? in_ready1  : in_ready0;
  assign s_vld  = sel ? out_valid1 : out_valid0;
  assign s_busy = sel ? busy1      : busy0;
  assign s_p    = sel ? out_p1     : out_p0;

  mult8_seq_ctrl #(.PIPE(0)) u_dut0 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid0),
    .in_ready  (in_ready0),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid0),
    .out_ready (out_ready),
    .out_p     (out_p0),
`ifdef MULT_MAC_ACC_EN
    .acc_clr   (acc_clr),
    .acc_out   (acc_out),
`endif
    .busy      (busy0)
  );

  mult8_seq_ctrl #(.PIPE(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid1),
    .out_ready (out_ready),
    .out_p     (out_p1),
`ifdef MULT_MAC_ACC_EN
    .acc_clr   (acc_clr1),
    .acc_out   (acc_out1),
`endif
    .busy      (busy1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One full transaction on the selected DUT with out_ready held high.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp,
                        input int lat, input logic clr);
    int n;
    @(negedge clk);
    in_a = a;
    in_b = b;
    v    = 1'b1;
    n = 0;
    while (!s_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_idle", s_rdy, 1);
    @(negedge clk);
    v    = 1'b0;
    in_a = ~a;
    in_b = ~b;
    chk("busy_mul", s_busy, 1);
    chk("in_ready_mul", s_rdy, 0);
    n = 0;
    while (!s_vld && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, lat);
    chk("out_p", s_p, exp);
`ifdef MULT_MAC_ACC_EN
    acc_clr = clr;
`else
    if (clr) $display("note: acc_clr request ignored in this build");
`endif
    @(negedge clk);
`ifdef MULT_MAC_ACC_EN
    acc_clr = 1'b0;
`endif
    chk("vld_drop", s_vld, 0);
    chk("rdy_back", s_rdy, 1);
  endtask

  initial begin
    int n, m0, m1, cnt;
    logic [15:0] e;
    rst = 1'b1; v = 1'b0; sel = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
`ifdef MULT_MAC_ACC_EN
    acc_clr = 1'b0; acc_clr1 = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_in_ready0", in_ready0, 1);
    chk("rst_out_valid0", out_valid0, 0);
    chk("rst_out_p0", out_p0, 0);
    chk("rst_busy0", busy0, 0);
    chk("rst_in_ready1", in_ready1, 1);
    chk("rst_out_valid1", out_valid1, 0);
    chk("rst_out_p1", out_p1, 0);
`ifdef MULT_MAC_ACC_EN
    chk("rst_acc_out", acc_out, 0);
`endif
    rst = 1'b0;

    // PIPE=0 basic and corner operands
    run_op(8'd3,   8'd5,   16'd15,    4, 1'b0);
    run_op(8'd255, 8'd255, 16'd65025, 4, 1'b0);
    run_op(8'd0,   8'd200, 16'd0,     4, 1'b0);
    run_op(8'd16,  8'd16,  16'd256,   4, 1'b0);
    run_op(8'd15,  8'd15,  16'd225,   4, 1'b0);
    run_op(8'd171, 8'd205, 16'd35055, 4, 1'b0);

    // backpressure: result held, new request ignored during the stall
    out_ready = 1'b0;
    @(negedge clk);
    in_a = 8'd100; in_b = 8'd200; v = 1'b1;
    @(negedge clk);
    v = 1'b0;
    n = 0;
    while (!out_valid0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_latency", n, 4);
    for (int k = 0; k < 10; k++) begin
      if (k == 0) begin
        in_a = 8'd1; in_b = 8'd1; v = 1'b1;
      end
      chk("bp_out_p", out_p0, 20000);
      chk("bp_out_valid", out_valid0, 1);
      chk("bp_in_ready", in_ready0, 0);
      @(negedge clk);
    end
    v = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_vld_drop", out_valid0, 0);
    chk("bp_out_p_after", out_p0, 20000);
    run_op(8'd2, 8'd3, 16'd6, 4, 1'b0);

    // async reset in the 2nd MUL cycle
    @(negedge clk);
    in_a = 8'd200; in_b = 8'd7; v = 1'b1;
    @(negedge clk);
    v = 1'b0;
    @(negedge clk);
    chk("pre_rst_busy", busy0, 1);
    chk("pre_rst_out_p", out_p0, 56);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", in_ready0, 1);
    chk("mid_rst_out_valid", out_valid0, 0);
    chk("mid_rst_out_p", out_p0, 0);
    chk("mid_rst_busy", busy0, 0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid0) cnt++;
    end
    chk("no_stale_vld", cnt, 0);
    run_op(8'd9, 8'd9, 16'd81, 4, 1'b0);

    // coarse operand sweep against a*b
    for (int i = 0; i < 256; i += 17) begin
      for (int j = 0; j < 256; j += 23) begin
        e = 16'(i * j);
        run_op(8'(i), 8'(j), e, 4, 1'b0);
      end
    end

    // PIPE=1: back-to-back with in_valid held high
    sel = 1'b1;
    @(negedge clk);
    in_a = 8'd12; in_b = 8'd34; v = 1'b1;
    n = 0;
    while (!in_ready1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    m0 = cyc;
    @(negedge clk);
    in_a = 8'd250; in_b = 8'd3;
    n = 0;
    while (!out_valid1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("p1_lat_a", cyc - (m0 + 1), 5);
    chk("p1_out_a", out_p1, 408);
    n = 0;
    @(negedge clk);
    while (!in_ready1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    m1 = cyc;
    chk("p1_issue_interval", m1 - m0, 7);
    @(negedge clk);
    v = 1'b0;
    n = 0;
    while (!out_valid1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("p1_lat_b", cyc - (m1 + 1), 5);
    chk("p1_out_b", out_p1, 750);
    @(negedge clk);
    chk("p1_vld_drop", out_valid1, 0);

    run_op(8'd255, 8'd255, 16'd65025, 5, 1'b0);
    run_op(8'd0,   8'd200, 16'd0,     5, 1'b0);
    run_op(8'd16,  8'd16,  16'd256,   5, 1'b0);
    run_op(8'd15,  8'd15,  16'd225,   5, 1'b0);
    for (int i = 0; i < 256; i += 51) begin
      for (int j = 0; j < 256; j += 51) begin
        e = 16'(i * j);
        run_op(8'(i), 8'(j), e, 5, 1'b0);
      end
    end
    sel = 1'b0;

`ifdef MULT_MAC_ACC_EN
    @(negedge clk);
    acc_clr = 1'b1;
    @(negedge clk);
    acc_clr = 1'b0;
    chk("mac_clr0", acc_out, 0);
    run_op(8'd25, 8'd40, 16'd1000, 4, 1'b0);
    run_op(8'd40, 8'd50, 16'd2000, 4, 1'b0);
    run_op(8'd50, 8'd60, 16'd3000, 4, 1'b0);
    chk("mac_sum", acc_out, 6000);
    run_op(8'd7, 8'd7, 16'd49, 4, 1'b1);
    chk("mac_clr_hs", acc_out, 49);
    @(negedge clk);
    acc_clr = 1'b1;
    @(negedge clk);
    acc_clr = 1'b0;
    chk("mac_clr1", acc_out, 0);
    repeat (20) run_op(8'd255, 8'd255, 16'd65025, 4, 1'b0);
    chk("mac_wrap", acc_out, 251924);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
